naive_bus_arbiter: RTL and testbench

Shares one naive_bus slave (instruction ROM, data RAM, or any peripheral slave) between `N_MASTER` naive_bus masters, e.g. the core's instruction-fetch and data ports. Each cycle at most one master is forwarded to the slave. Selection is round-robin or fixed-priority. The owner is held across slave stalls, and the one-cycle-late read data is routed back to the master whose read was granted.

---
 rtl/naive_bus_pkg.sv | 11 +
 rtl/naive_bus_if.sv | 25 ++
 rtl/rr_pick.sv | 23 ++
 rtl/naive_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_naive_bus_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/naive_bus_pkg.sv
// Shared types and constants for the naive_bus arbiter.
package naive_bus_pkg;

  localparam int unsigned NB_DATA_W = 32;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/naive_bus_if.sv
// naive_bus: split read/write request-grant bus; read data returns one cycle after rd_gnt.
interface naive_bus;
  import naive_bus_pkg::*;

  logic                 rd_req;
  logic                 rd_gnt;
  logic [31:0]          rd_addr;
  logic [NB_DATA_W-1:0] rd_data;
  logic                 wr_req;
  logic                 wr_gnt;
  logic [31:0]          wr_addr;
  logic [3:0]           wr_byte_en;
  logic [NB_DATA_W-1:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req searching from ptr upward, modulo N.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % int'(N);
      if (req[j]) idx = IdxW'(j);
    end
  end

endmodule

// File: rtl/naive_bus_arbiter.sv
// N-master to one-slave naive_bus arbiter with owner hold across stalls and read-data return.
// Define NAIVE_BUS_ARB_RR_EN for round-robin; otherwise fixed priority, master 0 highest.
module naive_bus_arbiter
  import naive_bus_pkg::*;
#(
  parameter int unsigned N_MASTER = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  naive_bus.slave  mst [N_MASTER],
  naive_bus.master slv
);

  localparam int unsigned IdxW = $clog2(N_MASTER);

  logic [N_MASTER-1:0]  m_rd_req, m_wr_req, m_req, m_rd_gnt, m_wr_gnt;
  logic [31:0]          m_rd_addr  [N_MASTER];
  logic [31:0]          m_wr_addr  [N_MASTER];
  logic [3:0]           m_wr_be    [N_MASTER];
  logic [NB_DATA_W-1:0] m_wr_data  [N_MASTER];
  logic [NB_DATA_W-1:0] m_rd_data  [N_MASTER];

  for (genvar g = 0; g < N_MASTER; g++) begin : g_mst
    assign m_rd_req[g]      = mst[g].rd_req;
    assign m_wr_req[g]      = mst[g].wr_req;
    assign m_rd_addr[g]     = mst[g].rd_addr;
    assign m_wr_addr[g]     = mst[g].wr_addr;
    assign m_wr_be[g]       = mst[g].wr_byte_en;
    assign m_wr_data[g]     = mst[g].wr_data;
    assign mst[g].rd_gnt    = m_rd_gnt[g];
    assign mst[g].wr_gnt    = m_wr_gnt[g];
    assign mst[g].rd_data   = m_rd_data[g];
  end

  assign m_req = m_rd_req | m_wr_req;

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     hold_idx_q, hold_idx_d;
  logic                rd_own_vld_q, rd_own_vld_d;
  logic [IdxW-1:0]     rd_own_idx_q, rd_own_idx_d;
  logic [IdxW-1:0]     pick_idx, sel_idx;
  logic                pick_any, sel_vld, fwd, done;

  // rr_ptr_q stays at zero under fixed priority, so this is the ptr=0 instance there.
  rr_pick #(
    .N    (N_MASTER),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req (m_req),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_idx = (state_q == HOLD) ? hold_idx_q : pick_idx;
  assign sel_vld = (state_q == HOLD) ? m_req[hold_idx_q] : pick_any;
  // Reset forces slave requests low, which in turn keeps every master grant low.
  assign fwd     = rst_n & sel_vld;

  assign slv.rd_req     = fwd & m_rd_req[sel_idx];
  assign slv.wr_req     = fwd & m_wr_req[sel_idx];
  assign slv.rd_addr    = m_rd_addr[sel_idx];
  assign slv.wr_addr    = m_wr_addr[sel_idx];
  assign slv.wr_byte_en = m_wr_be[sel_idx];
  assign slv.wr_data    = m_wr_data[sel_idx];

  assign done = (slv.rd_req & slv.rd_gnt) | (slv.wr_req & slv.wr_gnt);

  always_comb begin
    m_rd_gnt = '0;
    m_wr_gnt = '0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      m_rd_data[i] = '0;
      if (sel_idx == IdxW'(i)) begin
        m_rd_gnt[i] = slv.rd_req & slv.rd_gnt;
        m_wr_gnt[i] = slv.wr_req & slv.wr_gnt;
      end
      if (rd_own_vld_q && rd_own_idx_q == IdxW'(i)) m_rd_data[i] = slv.rd_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_idx_d   = hold_idx_q;
    rd_own_vld_d = slv.rd_req & slv.rd_gnt;
    rd_own_idx_d = rd_own_vld_d ? sel_idx : rd_own_idx_q;
    unique case (state_q)
      ARB: begin
        if (pick_any && !done) begin
          state_d    = HOLD;
          hold_idx_d = pick_idx;
        end
      end
      HOLD: begin
        // A held master dropping its request abandons the transfer.
        if (done || !sel_vld) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
`ifdef NAIVE_BUS_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (done) rr_ptr_d = (sel_idx == IdxW'(N_MASTER - 1)) ? '0 : sel_idx + 1'b1;
`else
    rr_ptr_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      hold_idx_q   <= '0;
      rd_own_vld_q <= 1'b0;
      rd_own_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_idx_q   <= hold_idx_d;
      rd_own_vld_q <= rd_own_vld_d;
      rd_own_idx_q <= rd_own_idx_d;
    end
  end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Directed bench for naive_bus_arbiter with two masters and a latency-1 ROM slave model.
module tb_naive_bus_arbiter;

`ifdef NAIVE_BUS_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  naive_bus mst_if [2] ();
  naive_bus slv_if ();

  logic [1:0]  m_rd_req, m_wr_req;
  logic [31:0] m_rd_addr [2];
  logic [31:0] m_wr_addr [2];
  logic [31:0] m_wr_data [2];
  logic [1:0]  o_rd_gnt, o_wr_gnt;
  logic [31:0] o_rd_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign mst_if[g].rd_req     = m_rd_req[g];
    assign mst_if[g].wr_req     = m_wr_req[g];
    assign mst_if[g].rd_addr    = m_rd_addr[g];
    assign mst_if[g].wr_addr    = m_wr_addr[g];
    assign mst_if[g].wr_data    = m_wr_data[g];
    assign mst_if[g].wr_byte_en = 4'hf;
    assign o_rd_gnt[g]          = mst_if[g].rd_gnt;
    assign o_wr_gnt[g]          = mst_if[g].wr_gnt;
    assign o_rd_data[g]         = mst_if[g].rd_data;
  end

  logic        s_rd_gnt, s_wr_gnt;
  logic [31:0] s_rd_data = '0;

  assign slv_if.rd_gnt  = s_rd_gnt;
  assign slv_if.wr_gnt  = s_wr_gnt;
  assign slv_if.rd_data = s_rd_data;

  // 18-word instruction ROM; addresses past the end read as zero.
  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    case (w)
      30'd0:   return 32'h000062b3;
      30'd1:   return 32'h000302b7;
      30'd2:   return 32'h06806313;
      default: return (w < 30'd18) ? {16'h1357, a[15:0]} : 32'h0;
    endcase
  endfunction

  // Slave keeps its last data when idle so stale values would leak if not gated.
  always_ff @(posedge clk) begin
    if (slv_if.rd_req && slv_if.rd_gnt) s_rd_data <= rom_rd(slv_if.rd_addr);
  end

  naive_bus_arbiter #(
    .N_MASTER (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mst   (mst_if),
    .slv   (slv_if)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_own;

  initial begin
    rst_n     = 1'b0;
    m_rd_req  = 2'b01;
    m_wr_req  = 2'b00;
    m_rd_addr = '{32'h0, 32'h0};
    m_wr_addr = '{32'h0, 32'h0};
    m_wr_data = '{32'h0, 32'h0};
    s_rd_gnt  = 1'b1;
    s_wr_gnt  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_slv_rd_req", 32'(slv_if.rd_req), 32'd0);
    check_eq("rst_m0_rd_gnt", 32'(o_rd_gnt[0]), 32'd0);
    check_eq("rst_m0_rd_data", o_rd_data[0], 32'h0);

    // Single read from m0 at 0x0.
    rst_n = 1'b1;
    m_rd_addr[0] = 32'h0;
    #1;
    check_eq("t1_m0_gnt", 32'(o_rd_gnt[0]), 32'd1);
    check_eq("t1_m1_gnt", 32'(o_rd_gnt[1]), 32'd0);
    step();
    check_eq("t1_m0_data", o_rd_data[0], 32'h000062b3);
    check_eq("t1_m1_data", o_rd_data[1], 32'h0);

    // Both masters read every cycle; under RR the pointer sits at 1 after m0's read.
    m_rd_req     = 2'b11;
    m_rd_addr[0] = 32'h4;
    m_rd_addr[1] = 32'h8;
    for (int k = 0; k < 4; k++) begin
      exp_own = RrEn ? ((k % 2 == 0) ? 1 : 0) : 0;
      #1;
      check_eq($sformatf("t2_m0_gnt_%0d", k), 32'(o_rd_gnt[0]), 32'(exp_own == 0));
      check_eq($sformatf("t2_m1_gnt_%0d", k), 32'(o_rd_gnt[1]), 32'(exp_own == 1));
      step();
      check_eq($sformatf("t2_m0_data_%0d", k), o_rd_data[0],
               (exp_own == 0) ? 32'h000302b7 : 32'h0);
      check_eq($sformatf("t2_m1_data_%0d", k), o_rd_data[1],
               (exp_own == 1) ? 32'h06806313 : 32'h0);
    end
    m_rd_req = 2'b00;

    // m1 write stalled three cycles; m0 starts reading in cycle 2 and must wait.
    m_wr_req[1]  = 1'b1;
    m_wr_addr[1] = 32'h30000;
    m_wr_data[1] = 32'h68;
    m_rd_addr[0] = 32'h0;
    s_wr_gnt     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) m_rd_req[0] = 1'b1;
      #1;
      check_eq($sformatf("t3_slv_wr_req_%0d", c), 32'(slv_if.wr_req), 32'd1);
      check_eq($sformatf("t3_slv_wr_addr_%0d", c), slv_if.wr_addr, 32'h30000);
      check_eq($sformatf("t3_slv_wr_data_%0d", c), slv_if.wr_data, 32'h68);
      check_eq($sformatf("t3_slv_rd_req_%0d", c), 32'(slv_if.rd_req), 32'd0);
      check_eq($sformatf("t3_m0_rd_gnt_%0d", c), 32'(o_rd_gnt[0]), 32'd0);
      step();
    end
    s_wr_gnt = 1'b1;
    #1;
    check_eq("t3_m1_wr_gnt", 32'(o_wr_gnt[1]), 32'd1);
    check_eq("t3_m0_rd_gnt_c3", 32'(o_rd_gnt[0]), 32'd0);
    step();
    // m1 keeps asking for another write; m0 still wins this cycle.
    #1;
    check_eq("t3_m0_rd_gnt_c4", 32'(o_rd_gnt[0]), 32'd1);
    check_eq("t3_m1_wr_gnt_c4", 32'(o_wr_gnt[1]), 32'd0);
    check_eq("t3_slv_wr_req_c4", 32'(slv_if.wr_req), 32'd0);
    step();
    check_eq("t3_m0_data", o_rd_data[0], 32'h000062b3);
    m_rd_req[0] = 1'b0;
    #1;
    check_eq("t3_m1_wr_gnt_c5", 32'(o_wr_gnt[1]), 32'd1);
    step();
    m_wr_req[1] = 1'b0;

    // Reset right after an m1 read grant drops the return.
    m_rd_req[1]  = 1'b1;
    m_rd_addr[1] = 32'h8;
    #1;
    check_eq("t4_m1_gnt", 32'(o_rd_gnt[1]), 32'd1);
    step();
    rst_n       = 1'b0;
    m_rd_req[1] = 1'b0;
    #1;
    check_eq("t4_m1_data_rst", o_rd_data[1], 32'h0);
    check_eq("t4_m0_data_rst", o_rd_data[0], 32'h0);
    step();
    rst_n        = 1'b1;
    m_rd_req     = 2'b11;
    m_rd_addr[0] = 32'h0;
    #1;
    check_eq("t4_m0_gnt_post", 32'(o_rd_gnt[0]), 32'd1);
    check_eq("t4_m1_gnt_post", 32'(o_rd_gnt[1]), 32'd0);
    step();
    check_eq("t4_m0_data_post", o_rd_data[0], 32'h000062b3);
    check_eq("t4_m1_data_post", o_rd_data[1], 32'h0);
    m_rd_req = 2'b00;

    // Read past the end of the ROM, then m1 is granted in the return cycle.
    m_rd_req[0]  = 1'b1;
    m_rd_addr[0] = 32'h48;
    #1;
    check_eq("t5_m0_gnt", 32'(o_rd_gnt[0]), 32'd1);
    step();
    m_rd_req = 2'b10;
    #1;
    check_eq("t5_m0_data", o_rd_data[0], 32'h0);
    check_eq("t5_m1_gnt", 32'(o_rd_gnt[1]), 32'd1);
    step();
    check_eq("t5_m1_data", o_rd_data[1], 32'h06806313);
    check_eq("t5_m0_data_idle", o_rd_data[0], 32'h0);
    m_rd_req = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
